iter_muldiv: RTL and testbench

- Parametrised iterative divide unit, one bit per cycle, with a start/ready/annul handshake.
- Sits beside the EX-stage ALU and produces the HI/LO pair for div/divu.
- EX holds start_i and asserts its stall request until ready_o pulses.
- Generalises the fixed 32-bit divider: WIDTH is a parameter, divide-by-zero is reported, and signed overflow is defined.
- Optionally also performs iterative mult/multu.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/iter_muldiv_if.sv | 27 ++
 rtl/iter_muldiv_step.sv | 53 +++++
 rtl/iter_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_iter_muldiv.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative divide/multiply unit and the EX stage that drives it.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CALC    = 2'b01,
    DIVZERO = 2'b10,
    DONE    = 2'b11
  } state_e;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MUL = 1'b1;

  // Handshake levels as seen from EX
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic ResultReady    = 1'b1;
  localparam logic ResultNotReady = 1'b0;

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between EX and the iterative divide/multiply unit.
interface iter_muldiv_if #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
);

  logic                 start_i;
  logic                 annul_i;
  logic                 signed_i;
  logic                 op_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 busy_o;
  logic                 ready_o;
  logic                 div_zero_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, div_zero_o, result_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, op_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, div_zero_o, result_o
  );

endinterface

// File: rtl/iter_muldiv_step.sv
// One combinational iteration on magnitudes: restoring-division step, or shift-add step
// when ITER_MULDIV_MUL_EN is defined and op selects multiply.
module iter_muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef ITER_MULDIV_MUL_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   partial;
  logic             fits;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Remainder stays below the divisor, so a WIDTH-bit difference is exact whenever it fits
  assign partial = {hi, lo[WIDTH-1]};
  assign fits    = (partial >= {1'b0, opnd});
  assign trial   = partial[WIDTH-1:0] - opnd;
  assign div_hi  = fits ? trial : partial[WIDTH-1:0];
  assign div_lo  = {lo[WIDTH-2:0], fits};

`ifdef ITER_MULDIV_MUL_EN
  logic [WIDTH:0] sum;

  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // Pick the step flavour for the operation in flight
  always_comb begin
    hi_next = div_hi;
    lo_next = div_lo;
    if (op == OP_MUL) begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_next = div_hi;
      lo_next = div_lo;
    end
  end
`else
  assign hi_next = div_hi;
  assign lo_next = div_lo;
`endif

endmodule

// File: rtl/iter_muldiv.sv
// Iterative one-bit-per-cycle divider producing {remainder, quotient}; defining
// ITER_MULDIV_MUL_EN adds an iterative multiplier selected by op_i.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  iter_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   opnd;
  logic               neg_quo;
  logic               neg_rem;
  logic               busy;
  logic               ready;
  logic               div_zero;
  logic [2*WIDTH-1:0] result;

  logic               sign1;
  logic               sign2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               is_mul_req;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] div_fixed;
  logic [2*WIDTH-1:0] final_result;

  // The magnitude of the most negative value is still exact when read as unsigned
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    if (neg) begin
      return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return x;
    end
  endfunction

  assign sign1 = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign sign2 = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign mag1  = neg_if(bus.opdata1_i, sign1);
  assign mag2  = neg_if(bus.opdata2_i, sign2);

`ifdef ITER_MULDIV_MUL_EN
  logic op_mul;

  function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic [2*WIDTH-1:0] x, input logic neg);
    if (neg) begin
      return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return x;
    end
  endfunction

  assign is_mul_req = (bus.op_i == OP_MUL);

  iter_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_mul),
    .hi      (hi),
    .lo      (lo),
    .opnd    (opnd),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );
`else
  logic unused_op;

  assign unused_op  = bus.op_i;
  assign is_mul_req = 1'b0;

  iter_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .hi      (hi),
    .lo      (lo),
    .opnd    (opnd),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );
`endif

  assign div_fixed = {neg_if(hi_next, neg_rem), neg_if(lo_next, neg_quo)};

  // Sign-corrected value of the final iteration
  always_comb begin
    final_result = div_fixed;
`ifdef ITER_MULDIV_MUL_EN
    if (op_mul == OP_MUL) begin
      final_result = neg_wide_if({hi_next, lo_next}, neg_quo);
    end else begin
      final_result = div_fixed;
    end
`endif
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      opnd     <= {WIDTH{1'b0}};
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      ready    <= ResultNotReady;
      div_zero <= 1'b0;
      result   <= {(2*WIDTH){1'b0}};
`ifdef ITER_MULDIV_MUL_EN
      op_mul   <= OP_DIV;
`endif
    end else begin
      ready    <= ResultNotReady;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            busy    <= 1'b1;
            cnt     <= {CNT_W{1'b0}};
            hi      <= {WIDTH{1'b0}};
            neg_quo <= sign1 ^ sign2;
            neg_rem <= sign1;
`ifdef ITER_MULDIV_MUL_EN
            op_mul  <= is_mul_req;
`endif
            if (is_mul_req) begin
              lo    <= mag2;
              opnd  <= mag1;
              state <= CALC;
            end else if (bus.opdata2_i == {WIDTH{1'b0}}) begin
              // Raw dividend is kept so it can be returned as the remainder
              lo    <= bus.opdata1_i;
              opnd  <= {WIDTH{1'b0}};
              state <= DIVZERO;
            end else begin
              lo    <= mag1;
              opnd  <= mag2;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt == LAST_CNT) begin
              result <= final_result;
              ready  <= ResultReady;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
        end
        DIVZERO: begin
          if (bus.annul_i) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result   <= {lo, {WIDTH{1'b1}}};
            ready    <= ResultReady;
            div_zero <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy;
  assign bus.ready_o    = ready;
  assign bus.div_zero_o = div_zero;
  assign bus.result_o   = result;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed self-checking bench for iter_muldiv at WIDTH=32; expectations follow ITER_MULDIV_MUL_EN.
module tb_iter_muldiv;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  iter_muldiv_if #(.WIDTH(W)) bus ();

  iter_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current IDLE cycle (cycle 0) and waits for ready_o;
  // cyc is the cycle ready_o was first seen, -1 if it never came. Returns in the following IDLE cycle.
  task automatic run_op(input logic sgn, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output logic [2*W-1:0] res, output logic dz);
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    tick();
    bus.start_i = 1'b0;
    cyc = -1;
    res = '0;
    dz  = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.ready_o) begin
        cyc = c;
        res = bus.result_o;
        dz  = bus.div_zero_o;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_i = 1'b0; bus.op_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
    checks++; if (bus.div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_divzero: got %b expected 0", bus.div_zero_o); end
    checks++; if (bus.result_o !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_div();
    int cyc; logic [2*W-1:0] res; logic dz;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, cyc, res, dz);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL udiv_latency: got %0d expected 33", cyc); end
    checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL udiv_100_7: got %h expected 000000020000000e", res); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL udiv_divzero: got %b expected 0", dz); end
    checks++; if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL udiv_after: got ready=%b busy=%b expected 0 0", bus.ready_o, bus.busy_o); end
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h10, cyc, res, dz);
    checks++; if (res !== 64'h0000000F_0FFFFFFF) begin errors++; $display("FAIL udiv_msb: got %h expected 0000000f0fffffff", res); end
  endtask

  task automatic test_signed_div();
    int cyc; logic [2*W-1:0] res; logic dz;
    run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, cyc, res, dz);
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL sdiv_m7_2: got %h expected fffffffffffffffd", res); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL sdiv_latency: got %0d expected 33", cyc); end
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, cyc, res, dz);
    checks++; if (res !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL sdiv_7_m2: got %h expected 00000001fffffffd", res); end
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'h10, cyc, res, dz);
    checks++; if (res !== 64'hFFFFFFFF_00000000) begin errors++; $display("FAIL sdiv_m1_16: got %h expected ffffffff00000000", res); end
  endtask

  task automatic test_overflow();
    int cyc; logic [2*W-1:0] res; logic dz;
    run_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, cyc, res, dz);
    checks++; if (res !== 64'h00000000_80000000) begin errors++; $display("FAIL sdiv_overflow: got %h expected 0000000080000000", res); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL overflow_divzero: got %b expected 0", dz); end
  endtask

  task automatic test_div_zero();
    int cyc; logic [2*W-1:0] res; logic dz;
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 1'b0, 32'd5, 32'd0, cyc, res, dz);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL divzero_latency s=%0d: got %0d expected 2", s, cyc); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL divzero_flag s=%0d: got %b expected 1", s, dz); end
      checks++; if (res !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL divzero_result s=%0d: got %h expected 00000005ffffffff", s, res); end
    end
  endtask

  task automatic test_annul();
    int first_ready = -1;
    logic busy11 = 1'b1;
    logic [2*W-1:0] res11 = '0;
    logic [2*W-1:0] res_done = '0;
    for (int c = 0; c <= 60; c++) begin
      bus.start_i   = (c == 0) || (c == 5) || (c == 12);
      bus.annul_i   = (c == 10);
      bus.signed_i  = 1'b0;
      bus.op_i      = 1'b0;
      bus.opdata1_i = (c == 5) ? 32'd9 : 32'd1000;
      bus.opdata2_i = (c == 5) ? 32'd0 : 32'd3;
      if (c == 11) begin
        busy11 = bus.busy_o;
        res11  = bus.result_o;
      end
      if (bus.ready_o && first_ready < 0) begin
        first_ready = c;
        res_done    = bus.result_o;
      end
      tick();
    end
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    checks++; if (busy11 !== 1'b0) begin errors++; $display("FAIL annul_busy: got %b expected 0", busy11); end
    checks++; if (res11 !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL annul_result_held: got %h expected 00000005ffffffff", res11); end
    checks++; if (first_ready !== 45) begin errors++; $display("FAIL annul_restart_cycle: got %0d expected 45", first_ready); end
    checks++; if (res_done !== 64'h00000001_0000014D) begin errors++; $display("FAIL annul_restart_result: got %h expected 000000010000014d", res_done); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [2*W-1:0] res; logic dz;
    run_op(1'b0, 1'b0, 32'd50, 32'd5, cyc, res, dz);
    checks++; if (res !== 64'h00000000_0000000A) begin errors++; $display("FAIL b2b_first: got %h expected 000000000000000a", res); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", bus.busy_o); end
    run_op(1'b1, 1'b0, 32'hFFFFFFF7, 32'd4, cyc, res, dz);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", cyc); end
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFE) begin errors++; $display("FAIL b2b_second: got %h expected fffffffffffffffe", res); end
  endtask

  task automatic test_reset_mid_op();
    int cyc; logic [2*W-1:0] res; logic dz;
    logic [2*W-1:0] exp_res;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.op_i = 1'b0;
    bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    tick();
    bus.start_i = 1'b0;
    repeat (5) tick();
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b expected 1", bus.busy_o); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.div_zero_o !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: got busy=%b ready=%b dz=%b expected 0 0 0", bus.busy_o, bus.ready_o, bus.div_zero_o);
    end
    checks++; if (bus.result_o !== 64'h0) begin errors++; $display("FAIL async_reset_result: got %h expected 0", bus.result_o); end
    tick();
    rst = 1'b0;
    tick();
`ifdef ITER_MULDIV_MUL_EN
    exp_res = 64'hFFFFFFFF_FFFFFFF1;
`else
    exp_res = 64'hFFFFFFFD_00000000;
`endif
    run_op(1'b1, 1'b1, 32'hFFFFFFFD, 32'd5, cyc, res, dz);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", cyc); end
    checks++; if (res !== exp_res) begin errors++; $display("FAIL mul_m3_5: got %h expected %h", res, exp_res); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mul_divzero: got %b expected 0", dz); end
  endtask

  initial begin
    test_reset();
    test_unsigned_div();
    test_signed_div();
    test_overflow();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
